// File: rtl/key_debounce.sv
// Push-button debouncer: two-flop synchronizer, sample-tick divider and a
// four-state acceptance FSM producing level, press/release pulses and toggle.
module key_debounce #(
  parameter int unsigned SAMPLE_DIV = 12000,
  parameter int unsigned STABLE_CNT = 20
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic KEY_IN,
  output logic KEY_LEVEL,
  output logic KEY_PRESS,
  output logic KEY_RELEASE,
  output logic KEY_TOGGLE
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned CNT_W = (STABLE_CNT > 2) ? $clog2(STABLE_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_toggle;
  logic             w_tick;
  logic             w_key_s;

  assign w_key_s = r_sync2;
  assign w_tick  = (r_div == DIV_LAST);

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= KEY_IN;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running sample divider; tick marks its terminal count.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Acceptance FSM: a new level must be seen on STABLE_CNT consecutive ticks.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= IDLE_LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_toggle  <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (w_tick) begin
        case (r_state)
          IDLE_LOW: begin
            if (w_key_s) begin
              r_state <= WAIT_HIGH;
              r_cnt   <= CNT_W'(1);
            end
          end
          WAIT_HIGH: begin
            if (!w_key_s) begin
              r_state <= IDLE_LOW;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state  <= IDLE_HIGH;
              r_cnt    <= '0;
              r_level  <= 1'b1;
              r_press  <= 1'b1;
              r_toggle <= ~r_toggle;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          IDLE_HIGH: begin
            if (!w_key_s) begin
              r_state <= WAIT_LOW;
              r_cnt   <= CNT_W'(1);
            end
          end
          WAIT_LOW: begin
            if (w_key_s) begin
              r_state <= IDLE_HIGH;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state   <= IDLE_LOW;
              r_cnt     <= '0;
              r_level   <= 1'b0;
              r_release <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign KEY_LEVEL   = r_level;
  assign KEY_PRESS   = r_press;
  assign KEY_RELEASE = r_release;
  assign KEY_TOGGLE  = r_toggle;

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 12000, clocks per debounce sample tick (1 ms at 12 MHz); legal range 2..2^24.
REQ-002 SHALL have parameter STABLE_CNT, default 20, number of consecutive agreeing sample ticks needed to accept a new level; legal range 2..255.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port KEY_IN  input  1  raw push-button, asynchronous to CLK, 1 = pressed.
REQ-006 SHALL have port KEY_LEVEL  output  1  debounced button level.
REQ-007 SHALL have port KEY_PRESS  output  1  one-cycle pulse on each accepted press.
REQ-008 SHALL have port KEY_RELEASE  output  1  one-cycle pulse on each accepted release.
REQ-009 SHALL have port KEY_TOGGLE  output  1  level that inverts on each accepted press; drives the downstream counter's DEC input.

Function
REQ-010 SHALL pass KEY_IN through a two-flop synchronizer; the second flop output (key_s) is the only form of KEY_IN used elsewhere.
REQ-011 SHALL contain a tick divider counting 0..SAMPLE_DIV-1, wrapping to 0; tick is asserted in the cycle where the divider equals SAMPLE_DIV-1.
REQ-012 SHALL implement FSM states IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW; the FSM and the stable counter update only in tick cycles.
REQ-013 IDLE_LOW on tick: key_s=1 -> WAIT_HIGH with stable counter = 1; otherwise remain.
REQ-014 WAIT_HIGH on tick: key_s=0 -> IDLE_LOW, counter cleared, no pulse; key_s=1 with counter = STABLE_CNT-1 -> IDLE_HIGH; otherwise counter +1.
REQ-015 IDLE_HIGH and WAIT_LOW SHALL mirror REQ-013/REQ-014 with the key_s polarity inverted, ending in IDLE_LOW.
REQ-016 On the WAIT_HIGH -> IDLE_HIGH edge, SHALL set KEY_LEVEL=1, assert KEY_PRESS for exactly that one following cycle, and invert KEY_TOGGLE, all registered at the same edge.
REQ-017 On the WAIT_LOW -> IDLE_LOW edge, SHALL set KEY_LEVEL=0 and assert KEY_RELEASE for exactly one cycle; KEY_TOGGLE is unchanged.
REQ-018 KEY_PRESS and KEY_RELEASE SHALL never be high in the same cycle; neither SHALL be high for two consecutive cycles.
REQ-019 Glitches of any width between ticks SHALL be ignored; a single disagreeing sample in a WAIT state SHALL abort the transition.
REQ-020 The stable counter SHALL be wide enough for STABLE_CNT-1 and never wraps (bounded by REQ-014).
REQ-021 KEY_LEVEL SHALL equal 0 in IDLE_LOW/WAIT_HIGH and 1 in IDLE_HIGH/WAIT_LOW.

Reset
REQ-022 RESET_N=0 SHALL immediately force: synchronizer flops 0, divider 0, stable counter 0, FSM IDLE_LOW, KEY_LEVEL=0, KEY_PRESS=0, KEY_RELEASE=0, KEY_TOGGLE=0.
REQ-023 Reset asserted in any WAIT state or while a pulse is high SHALL drop to REQ-022 values with no pulse emitted afterwards.
REQ-024 After RESET_N deassertion, the first tick SHALL occur SAMPLE_DIV cycles later.

Verification (SAMPLE_DIV=4, STABLE_CNT=3)
REQ-025 Reset, then KEY_IN=1 held -> KEY_PRESS one cycle after the 3rd tick at which key_s=1; KEY_LEVEL=1; KEY_TOGGLE=1.
REQ-026 KEY_IN high for 2 ticks, then low at the 3rd tick -> no KEY_PRESS; FSM back to IDLE_LOW; KEY_LEVEL stays 0.
REQ-027 1-cycle KEY_IN pulses placed between ticks, repeated 50 times -> KEY_LEVEL, KEY_PRESS and KEY_TOGGLE unchanged.
REQ-028 Two full press/release cycles -> KEY_PRESS, KEY_RELEASE, KEY_PRESS, KEY_RELEASE pulses in order, each exactly 1 cycle; KEY_TOGGLE goes 0->1->0.
REQ-029 RESET_N pulsed low during WAIT_HIGH after 2 good ticks -> all outputs 0 at once; with KEY_IN still 1, the press is accepted only after 3 fresh ticks.
REQ-030 Randomized KEY_IN with an assertion monitor -> REQ-018 and REQ-021 hold on every cycle.
